// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: JAL opcode, fetch state encoding and
// J-type immediate extraction.
package fetch_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // Sign-extended J-type immediate; bit 0 is always zero.
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_jal_predecode.sv
// Combinational JAL pre-decode: opcode match and jump target for the
// instruction currently returned by the cache.
module jal_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        is_jal,
  output logic [31:0] target
);

  assign is_jal = (instr[6:0] == OPC_JAL);
  assign target = pc + j_imm(instr);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the cache address, tracks the one
// in-flight read and hands instructions to decode under valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter bit          JAL_PREDICT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] FETCH_PC,
  input  logic [31:0] MEM_INSTR,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic        IF_VALID,
  output logic        IF_PRED,
  input  logic        ID_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        HALT_REQ,
  output logic        FETCH_FAULT,
  output logic [31:0] FAULT_PC
);

  fetch_state_e state_q, state_next;

  logic [31:0] pc_q;
  logic        inf_v;
  logic [31:0] inf_pc;
  logic        fault_q;
  logic [31:0] fault_pc_q;

  logic        if_valid;
  logic        hold;
  logic        pred_cond;
  logic        jal_hit;
  logic [31:0] fetch_pc;
  logic        issue_req;
  logic        misaligned;
  logic        do_issue;
  logic        do_fault;
  logic        fault_exit;

  logic        is_jal;
  logic [31:0] jal_target;

  jal_predecode u_predecode (
    .instr  (MEM_INSTR),
    .pc     (inf_pc),
    .is_jal (is_jal),
    .target (jal_target)
  );

  always_ff @(posedge CLK or posedge RST) begin : state_reg
    if (RST) state_q <= ST_RUN;
    else     state_q <= state_next;
  end

  // While halted a redirect only retargets pc_q; a held word keeps being re-read.
  always_comb begin : next_state
    issue_req  = 1'b0;
    state_next = state_q;
    case (state_q)
      ST_RUN:   issue_req = REDIRECT ? !HALT_REQ : (hold | !HALT_REQ);
      ST_FAULT: issue_req = REDIRECT & !HALT_REQ;
      default:  issue_req = 1'b0;
    endcase
    misaligned = (fetch_pc[1:0] != 2'b00);
    do_issue   = issue_req & !misaligned;
    do_fault   = issue_req & misaligned;
    fault_exit = (state_q == ST_FAULT) & REDIRECT & (REDIRECT_PC[1:0] == 2'b00);
    if (do_fault)        state_next = ST_FAULT;
    else if (fault_exit) state_next = ST_RUN;
  end

  always_comb begin : outputs
    if_valid  = inf_v & !REDIRECT & (state_q == ST_RUN);
    hold      = inf_v & !ID_READY & !REDIRECT;
    pred_cond = JAL_PREDICT & if_valid & is_jal;
    jal_hit   = pred_cond & ID_READY;
    if (REDIRECT)     fetch_pc = REDIRECT_PC;
    else if (hold)    fetch_pc = inf_pc;
    else if (jal_hit) fetch_pc = jal_target;
    else              fetch_pc = pc_q;
  end

  always_ff @(posedge CLK or posedge RST) begin : datapath
    if (RST) begin
      pc_q       <= RESET_PC;
      inf_v      <= 1'b0;
      inf_pc     <= 32'h0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      if (do_issue) begin
        inf_v  <= 1'b1;
        inf_pc <= fetch_pc;
        pc_q   <= fetch_pc + 32'd4;
      end else begin
        inf_v <= 1'b0;
        if (REDIRECT) pc_q <= REDIRECT_PC;
      end
      if (do_fault) begin
        fault_q    <= 1'b1;
        fault_pc_q <= fetch_pc;
      end else if (fault_exit) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign FETCH_PC    = fetch_pc;
  assign IF_INSTR    = MEM_INSTR;
  assign IF_PC       = inf_pc;
  assign IF_VALID    = if_valid;
  assign IF_PRED     = pred_cond;
  assign FETCH_FAULT = fault_q;
  assign FAULT_PC    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected transfers into a
// queue, a negedge monitor pops and compares every accepted instruction.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] FETCH_PC;
  logic [31:0] MEM_INSTR;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        IF_VALID;
  logic        IF_PRED;
  logic        ID_READY = 1'b1;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        HALT_REQ = 1'b0;
  logic        FETCH_FAULT;
  logic [31:0] FAULT_PC;

  fetch_unit #(.RESET_PC(32'h0000_0000), .JAL_PREDICT(1'b1)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .FETCH_PC    (FETCH_PC),
    .MEM_INSTR   (MEM_INSTR),
    .IF_INSTR    (IF_INSTR),
    .IF_PC       (IF_PC),
    .IF_VALID    (IF_VALID),
    .IF_PRED     (IF_PRED),
    .ID_READY    (ID_READY),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .HALT_REQ    (HALT_REQ),
    .FETCH_FAULT (FETCH_FAULT),
    .FAULT_PC    (FAULT_PC)
  );

  always #5 CLK = ~CLK;

  // Cache model: one-cycle registered read of the word at FETCH_PC.
  logic [31:0] mem [0:63];
  always @(posedge CLK) MEM_INSTR <= mem[FETCH_PC[7:2]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t mon_e;
  int    vectors     = 0;
  int    miscompares = 0;

  localparam logic [31:0] JAL_P16 = 32'h0100_00EF;  // jal ra, +16

  function automatic logic [31:0] word_at(input int idx);
    return 32'h0000_0013 | (32'(idx) << 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_xfer(input logic [31:0] pc, input logic pred);
    xfer_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:2]];
    e.pred  = pred;
    exp_q.push_back(e);
  endtask

  // One clock: wait for the edge, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc, input logic hlt);
    @(posedge CLK);
    #2;
    ID_READY    = rdy;
    REDIRECT    = rd;
    REDIRECT_PC = rpc;
    HALT_REQ    = hlt;
    #1;
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    ID_READY    = 1'b1;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'h0;
    HALT_REQ    = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_if_valid", 32'(IF_VALID), 32'h0);
    chk("rst_if_pred", 32'(IF_PRED), 32'h0);
    chk("rst_fetch_fault", 32'(FETCH_FAULT), 32'h0);
    chk("rst_fault_pc", FAULT_PC, 32'h0);
    chk("rst_fetch_pc", FETCH_PC, 32'h0);
    RST = 1'b0;
  endtask

  task automatic end_scenario(input string name);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    #1;
    chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic valid_at(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(IF_VALID), 32'h1);
    chk({name, "_pc"}, IF_PC, pc);
  endtask

  always @(negedge CLK) begin
    if (!RST && IF_VALID && ID_READY) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_xfer: got pc %h, expected no transfer", IF_PC);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_pc", IF_PC, mon_e.pc);
        chk("xfer_instr", IF_INSTR, mon_e.instr);
        chk("xfer_pred", 32'(IF_PRED), 32'(mon_e.pred));
        $display("xfer pc=%h instr=%h pred=%0d", IF_PC, IF_INSTR, IF_PRED);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word_at(i);

    // Sequential stream from reset: word 0 is delivered.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      valid_at("seq", 32'(i * 4));
      expect_xfer(32'(i * 4), 1'b0);
    end
    end_scenario("seq");

    // Decode stall at 0x8 for three cycles.
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      valid_at("stall", 32'h8);
      chk("stall_fetch_pc", FETCH_PC, 32'h8);
      chk("stall_instr", IF_INSTR, word_at(2));
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("stall_rel", 32'h8); expect_xfer(32'h8, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("stall_next", 32'hC); expect_xfer(32'hC, 1'b0);
    end_scenario("stall");

    // Predicted JAL at 0x8, first stalled one cycle, then taken to 0x18.
    mem[2] = JAL_P16;
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h4, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("jal_stall_pred", 32'(IF_PRED), 32'h1);
    chk("jal_stall_fetch_pc", FETCH_PC, 32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("jal_fetch_pc", FETCH_PC, 32'h18);
    expect_xfer(32'h8, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("jal_tgt", 32'h18); expect_xfer(32'h18, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("jal_seq", 32'h1C); expect_xfer(32'h1C, 1'b0);
    end_scenario("jal");
    mem[2] = word_at(2);

    // Redirect squashes 0x10, then misaligned redirect faults, aligned one recovers.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      expect_xfer(32'(i * 4), 1'b0);
    end
    cyc(1'b1, 1'b1, 32'h40, 1'b0);
    chk("redir_squash_valid", 32'(IF_VALID), 32'h0);
    chk("redir_squash_pc", IF_PC, 32'h10);
    chk("redir_fetch_pc", FETCH_PC, 32'h40);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("redir_tgt", 32'h40); expect_xfer(32'h40, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h44, 1'b0);
    cyc(1'b1, 1'b1, 32'h42, 1'b0);
    chk("mis_redir_valid", 32'(IF_VALID), 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("fault_flag", 32'(FETCH_FAULT), 32'h1);
      chk("fault_pc", FAULT_PC, 32'h42);
      chk("fault_valid", 32'(IF_VALID), 32'h0);
    end
    cyc(1'b1, 1'b1, 32'h20, 1'b0);
    chk("fault_exit_valid", 32'(IF_VALID), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("fault_cleared", 32'(FETCH_FAULT), 32'h0);
    valid_at("fault_exit_tgt", 32'h20);
    expect_xfer(32'h20, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h24, 1'b0);
    end_scenario("redirect");

    // Halt after 0x4, release, then asynchronous reset while stalled.
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0); expect_xfer(32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1); valid_at("halt_last", 32'h4); expect_xfer(32'h4, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1); chk("halt_idle1", 32'(IF_VALID), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1); chk("halt_idle2", 32'(IF_VALID), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); chk("halt_rel_gap", 32'(IF_VALID), 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("halt_resume", 32'h8); expect_xfer(32'h8, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0); valid_at("pre_rst_stall", 32'hC);
    RST = 1'b1;
    #1;
    chk("async_rst_valid", 32'(IF_VALID), 32'h0);
    do_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0); valid_at("restart", 32'h0); expect_xfer(32'h0, 1'b0);
    end_scenario("halt_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
